sha256_compress: RTL

SHA-256 block compression stage sitting directly downstream of the message preprocessor. It accepts one 512-bit padded block as sixteen 32-bit big-endian words on a `tra_start` request, expands the message schedule on the fly, runs 64 compression rounds, accumulates the result into the running hash H0..H7 and reports completion via `st_tra`. The final 256-bit digest is published when the preprocessor signals `FINISH_FLAG`.

---
 rtl/sha256_compress.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_compress.sv
// SHA-256 block compression stage.
//
// Takes one 512-bit padded block (sixteen 32-bit big-endian words) per request.
// Expands the message schedule on the fly in a 16-word shift register.
// Runs the 64 compression rounds, then adds the result into the running hash H0..H7.
// The handshake reports progress through st_tra.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   tra_start    block request, any nonzero value means request; held until st_tra==3
//   w            block words, w[0] is the most significant word; sampled in LOAD only
//   FINISH_FLAG  last block of the message is complete; sampled in DONE only
//   st_tra       state code: 0 IDLE, 1 LOAD, 2 ROUND, 4 UPDATE, 3 DONE
//   digest       H0..H7, with H0 in bits [255:224]
//   digest_valid digest holds a finished message hash
//
// Build option:
//   SHA256_UNROLL2_EN  when defined, two rounds per cycle (32 ROUND cycles instead of 64)

module sha256_compress (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        tra_start,
  input  logic [0:15][31:0]  w,
  input  logic               FINISH_FLAG,
  output logic [31:0]        st_tra,
  output logic [255:0]       digest,
  output logic               digest_valid
);

  typedef logic [0:7][31:0] hash_t;

  // Encodings match the externally visible st_tra codes.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StRound  = 3'd2,
    StDone   = 3'd3,
    StUpdate = 3'd4
  } state_e;

  localparam hash_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

`ifdef SHA256_UNROLL2_EN
  localparam logic [5:0] TStep = 6'd2;
  localparam logic [5:0] TLast = 6'd62;
`else
  localparam logic [5:0] TStep = 6'd1;
  localparam logic [5:0] TLast = 6'd63;
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // One compression round on working vars s = {a,b,c,d,e,f,g,h}.
  function automatic hash_t round_fn(input hash_t s, input logic [31:0] k,
                                     input logic [31:0] wt);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + wt;
    t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction

  state_e              state_q;
  hash_t               h_q;
  hash_t               wv_q;
  logic [0:15][31:0]   sched_q;
  logic [5:0]          t_q;
  logic                init_pending_q;
  logic                digest_valid_q;

  hash_t               wv_next;
  logic [0:15][31:0]   sched_next;

  always_comb begin
    wv_next    = round_fn(wv_q, K[t_q], sched_q[0]);
`ifdef SHA256_UNROLL2_EN
    wv_next    = round_fn(wv_next, K[t_q + 6'd1], sched_q[1]);
    // W[t+16] and W[t+17]; the second needs only words already in the register.
    sched_next = {sched_q[2:15],
                  ssig1(sched_q[14]) + sched_q[9] + ssig0(sched_q[1]) + sched_q[0],
                  ssig1(sched_q[15]) + sched_q[10] + ssig0(sched_q[2]) + sched_q[1]};
`else
    sched_next = {sched_q[1:15],
                  ssig1(sched_q[14]) + sched_q[9] + ssig0(sched_q[1]) + sched_q[0]};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      h_q            <= IV;
      wv_q           <= '0;
      sched_q        <= '0;
      t_q            <= '0;
      init_pending_q <= 1'b1;
      digest_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tra_start != '0) state_q <= StLoad;
        end
        StLoad: begin
          sched_q <= w;
          // First block of a message starts from the IV; later blocks chain from H.
          if (init_pending_q) begin
            h_q            <= IV;
            wv_q           <= IV;
            init_pending_q <= 1'b0;
          end else begin
            wv_q <= h_q;
          end
          digest_valid_q <= 1'b0;
          t_q            <= '0;
          state_q        <= StRound;
        end
        StRound: begin
          wv_q    <= wv_next;
          sched_q <= sched_next;
          t_q     <= t_q + TStep;
          if (t_q == TLast) state_q <= StUpdate;
        end
        StUpdate: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
          state_q <= StDone;
        end
        StDone: begin
          if (tra_start == '0) begin
            if (FINISH_FLAG) begin
              digest_valid_q <= 1'b1;
              init_pending_q <= 1'b1;
            end
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign st_tra       = {29'd0, state_q};
  assign digest       = h_q;
  assign digest_valid = digest_valid_q;

endmodule
